ovf_range_store: RTL

- Storage and responder side of the heap-overflow detection path.
- The store-tracking unit sends completed byte-store intervals [first,last]; this block keeps them in a circular table of DEPTH entries.
- It answers same-cycle "is this load address inside a recorded overflow?" queries from the load-check path.
- Sits beside the load/store unit; write side driven by the tracker, query side by the load-check logic.

---
 rtl/ovf_range_store_pkg.sv | 13 +
 rtl/ovf_range_store_match.sv | 14 +
 rtl/ovf_range_store.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ovf_range_store_pkg.sv
// Shared types and defaults for the overflow interval store.
package ovf_range_store_pkg;

    localparam int unsigned OVF_DEPTH_DEFAULT = 8;
    localparam int unsigned OVF_AW_DEFAULT    = 32;

    typedef struct packed {
        logic                      valid;
        logic [OVF_AW_DEFAULT-1:0] first;
        logic [OVF_AW_DEFAULT-1:0] last;
    } ovf_range_t;

endpackage

// File: rtl/ovf_range_store_match.sv
// One table entry compared against a load address: inclusive unsigned range test.
module ovf_range_store_match #(
    parameter int unsigned AW = 32
) (
    input  logic          valid,
    input  logic [AW-1:0] first,
    input  logic [AW-1:0] last,
    input  logic [AW-1:0] addr,
    output logic          hit_c
);

    assign hit_c = valid && (addr >= first) && (addr <= last);

endmodule

// File: rtl/ovf_range_store.sv
// Circular table of recorded overflow byte intervals with a zero-latency address query.
// Optional OVF_RANGE_MERGE_EN: writes touching the most recent entry extend it in place.
module ovf_range_store
    import ovf_range_store_pkg::*;
#(
    parameter int unsigned DEPTH = OVF_DEPTH_DEFAULT,
    parameter int unsigned AW    = OVF_AW_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       wr_en_i,
    input  logic [AW-1:0]              wr_first_i,
    input  logic [AW-1:0]              wr_last_i,
    input  logic [AW-1:0]              query_addr_i,
    output logic                       hit_o,
    output logic [$clog2(DEPTH)-1:0]   hit_idx_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic [AW-1:0]              last_first_o,
    output logic [AW-1:0]              last_last_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    first_q [DEPTH];
    logic [AW-1:0]    last_q  [DEPTH];
    logic [IW-1:0]    ptr_q;
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    last_first_q;
    logic [AW-1:0]    last_last_q;
    logic [15:0]      drop_q;

    logic             accept_c;
    logic             reject_c;
    logic             merge_c;
    logic [IW-1:0]    wr_idx_c;
    logic [AW-1:0]    new_first_c;
    logic [AW-1:0]    new_last_c;
    logic [DEPTH-1:0] hits_c;
    logic [IW-1:0]    hit_idx_c;

    // Clear outranks a write; a cleared write is neither stored nor dropped.
    assign accept_c = wr_en_i && !clear_i && (wr_first_i <= wr_last_i);
    assign reject_c = wr_en_i && !clear_i && (wr_first_i >  wr_last_i);

`ifdef OVF_RANGE_MERGE_EN
    localparam int unsigned AW1 = AW + 1;

    logic [IW-1:0] prev_idx_c;
    logic [AW:0]   prev_last_inc_c;
    logic [AW:0]   wr_last_inc_c;

    // One extra bit keeps the +1 adjacency test from wrapping at the address max.
    assign prev_idx_c      = ptr_q - IW'(1);
    assign prev_last_inc_c = {1'b0, last_q[prev_idx_c]} + AW1'(1);
    assign wr_last_inc_c   = {1'b0, wr_last_i} + AW1'(1);
    assign merge_c         = accept_c && valid_q[prev_idx_c]
                             && ({1'b0, wr_first_i} <= prev_last_inc_c)
                             && (wr_last_inc_c >= {1'b0, first_q[prev_idx_c]});

    always_comb begin
        wr_idx_c    = ptr_q;
        new_first_c = wr_first_i;
        new_last_c  = wr_last_i;
        if (merge_c) begin
            wr_idx_c    = prev_idx_c;
            new_first_c = (first_q[prev_idx_c] < wr_first_i) ? first_q[prev_idx_c] : wr_first_i;
            new_last_c  = (last_q[prev_idx_c]  > wr_last_i)  ? last_q[prev_idx_c]  : wr_last_i;
        end
    end
`else
    assign merge_c     = 1'b0;
    assign wr_idx_c    = ptr_q;
    assign new_first_c = wr_first_i;
    assign new_last_c  = wr_last_i;
`endif

    // Entry storage; data of cleared entries is left stale behind valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                first_q[i] <= '0;
                last_q[i]  <= '0;
            end
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (accept_c) begin
            valid_q[wr_idx_c] <= 1'b1;
            first_q[wr_idx_c] <= new_first_c;
            last_q[wr_idx_c]  <= new_last_c;
        end
    end

    // Pointer, occupancy and last-written bounds; a full table overwrites the oldest.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q        <= '0;
            count_q      <= '0;
            last_first_q <= '0;
            last_last_q  <= '0;
        end else if (clear_i) begin
            ptr_q        <= '0;
            count_q      <= '0;
            last_first_q <= '0;
            last_last_q  <= '0;
        end else if (accept_c) begin
            last_first_q <= new_first_c;
            last_last_q  <= new_last_c;
            if (!merge_c) begin
                ptr_q <= ptr_q + IW'(1);
                if (count_q != CW'(DEPTH)) begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

    // Rejected-write counter survives clear and saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= '0;
        end else if (reject_c && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        ovf_range_store_match #(
            .AW (AW)
        ) u_match (
            .valid (valid_q[g]),
            .first (first_q[g]),
            .last  (last_q[g]),
            .addr  (query_addr_i),
            .hit_c (hits_c[g])
        );
    end

    // Lowest hitting index wins; zero when nothing hits.
    always_comb begin
        hit_idx_c = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hits_c[i]) begin
                hit_idx_c = IW'(i);
            end
        end
    end

    assign hit_o        = |hits_c;
    assign hit_idx_o    = hit_idx_c;
    assign count_o      = count_q;
    assign full_o       = (count_q == CW'(DEPTH));
    assign last_first_o = last_first_q;
    assign last_last_o  = last_last_q;
    assign drop_cnt_o   = drop_q;

endmodule
